// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl
//   Bit-timing controller for the UART transmit path. A one-cycle send
//   request starts a frame. The block then steps a 4-bit bit index through
//   the frame: 0 is the start bit, 1..8 are the data bits (LSB first) and
//   9..8+STOP_BITS are the stop bits. The index advances every CLK_PER_BIT
//   clocks. The TX serialiser downstream latches its data on send_start and
//   drives the line from baud_busy/baud_counte.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous reset, active low
//   send_start   in   1  one-cycle frame request, honoured only when send_ready=1
//   send_ready   out  1  1 while IDLE (decoded from the state register)
//   baud_busy    out  1  high from the start bit through the last stop bit
//   baud_counte  out  4  current bit index, 0 when idle
//   send_done    out  1  one-cycle pulse in the first idle cycle after a frame

module uart_baud_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_start,
  output logic       send_ready,
  output logic       baud_busy,
  output logic [3:0] baud_counte,
  output logic       send_done
);

  localparam int CLK_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int DIV_W       = (CLK_PER_BIT < 2) ? 1 : $clog2(CLK_PER_BIT);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [3:0]       LAST_IDX = 4'(8 + STOP_BITS);

  // Reject parameter sets that cannot produce a valid frame.
  if (CLK_PER_BIT < 2) begin : g_bad_div
    $error("uart_baud_ctrl: CLK_PER_BIT must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_baud_ctrl: STOP_BITS must be 1 or 2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [DIV_W-1:0]  div_cnt_s;
  logic [3:0]        bit_idx_r;
  logic [3:0]        bit_idx_s;
  logic              busy_r;
  logic              busy_s;
  logic              done_r;
  logic              done_s;

  // State, divider and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= DIV_ZERO;
      bit_idx_r <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_cnt_r <= div_cnt_s;
      bit_idx_r <= bit_idx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  // Next-state logic: start on request in IDLE, step bit index every CLK_PER_BIT clocks in SEND.
  always_comb begin
    state_s   = state_r;
    div_cnt_s = div_cnt_r;
    bit_idx_s = bit_idx_r;
    busy_s    = busy_r;
    done_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        div_cnt_s = DIV_ZERO;
        bit_idx_s = 4'd0;
        if (send_start) begin
          state_s = ST_SEND;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end

      // send_start is deliberately not looked at here: requests while a
      // frame is running are dropped, never queued.
      ST_SEND: begin
        if (div_cnt_r == DIV_MAX) begin
          div_cnt_s = DIV_ZERO;
          if (bit_idx_r == LAST_IDX) begin
            state_s   = ST_IDLE;
            busy_s    = 1'b0;
            bit_idx_s = 4'd0;
            done_s    = 1'b1;
          end else begin
            bit_idx_s = bit_idx_r + 4'd1;
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_ONE;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        div_cnt_s = DIV_ZERO;
        bit_idx_s = 4'd0;
        busy_s    = 1'b0;
      end
    endcase
  end

  assign send_ready  = (state_r == ST_IDLE);
  assign baud_busy   = busy_r;
  assign baud_counte = bit_idx_r;
  assign send_done   = done_r;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl
//   Directed bench for uart_baud_ctrl with CLK_PER_BIT=8. One instance uses
//   STOP_BITS=1. A second instance uses STOP_BITS=2 and drives a small
//   serialiser model, so the line bits of a full frame can be checked.

module tb_uart_baud_ctrl;

  logic       clk;
  logic       rst_n;
  logic       send_start;
  logic       send_ready;
  logic       baud_busy;
  logic [3:0] baud_counte;
  logic       send_done;

  logic       send_start2;
  logic       send_ready2;
  logic       baud_busy2;
  logic [3:0] baud_counte2;
  logic       send_done2;

  logic [7:0] tx_data2;
  logic [7:0] ser_data;
  logic       line;

  int n_checks;
  int n_errors;

  uart_baud_ctrl #(.CLK_FREQ(8), .BAUD_RATE(1), .STOP_BITS(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .send_start (send_start),
    .send_ready (send_ready),
    .baud_busy  (baud_busy),
    .baud_counte(baud_counte),
    .send_done  (send_done)
  );

  uart_baud_ctrl #(.CLK_FREQ(8), .BAUD_RATE(1), .STOP_BITS(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .send_start (send_start2),
    .send_ready (send_ready2),
    .baud_busy  (baud_busy2),
    .baud_counte(baud_counte2),
    .send_done  (send_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serialiser model: latch data on send_start and drive the line one cycle behind the bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_data <= 8'h00;
      line     <= 1'b1;
    end else begin
      if (send_start2) ser_data <= tx_data2;
      if (!baud_busy2) line <= 1'b1;
      else if (baud_counte2 == 4'd0) line <= 1'b0;
      else if (baud_counte2 <= 4'd8) line <= ser_data[3'(baud_counte2 - 4'd1)];
      else line <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pack {ready, busy, index, done} into one value for comparison.
  function automatic logic [31:0] pack1(input logic r, input logic b, input logic [3:0] i, input logic d);
    return {25'd0, r, b, i, d};
  endfunction

  // Run one STOP_BITS=1 frame. The caller is in the cycle where send_start is set.
  // mode 1 adds ignored requests at index 3 (pulse) and index 6 (held 20 cycles).
  // With chain set, a new request is raised in the send_done cycle.
  task automatic frame1(input int mode, input bit chain, input string tag);
    logic [3:0] e_idx;
    send_start = 1'b1;
    for (int c = 1; c <= 81; c++) begin
      tick();
      send_start = ((mode == 1) && ((c == 26) || (c >= 50 && c < 70))) || (chain && c == 81);
      if (c <= 80) begin
        e_idx = 4'((c - 1) / 8);
        check(tag, pack1(send_ready, baud_busy, baud_counte, send_done), pack1(1'b0, 1'b1, e_idx, 1'b0));
      end else begin
        check(tag, pack1(send_ready, baud_busy, baud_counte, send_done), pack1(1'b1, 1'b0, 4'd0, 1'b1));
      end
    end
  endtask

  initial begin
    logic [10:0] exp_line;
    logic [3:0]  e_idx;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    send_start  = 1'b0;
    send_start2 = 1'b0;
    tx_data2    = 8'h00;

    // Reset held low for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset", pack1(send_ready, baud_busy, baud_counte, send_done), pack1(1'b1, 1'b0, 4'd0, 1'b0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle", pack1(send_ready, baud_busy, baud_counte, send_done), pack1(1'b1, 1'b0, 4'd0, 1'b0));
    end

    // Single frame.
    frame1(0, 1'b0, "frame");
    tick();
    check("post_done", pack1(send_ready, baud_busy, baud_counte, send_done), pack1(1'b1, 1'b0, 4'd0, 1'b0));

    // Requests during the frame must be ignored.
    tick();
    frame1(1, 1'b0, "ignored_req");
    tick();
    check("post_ignored", pack1(send_ready, baud_busy, baud_counte, send_done), pack1(1'b1, 1'b0, 4'd0, 1'b0));

    // Back-to-back: the request in the send_done cycle is accepted.
    tick();
    frame1(0, 1'b1, "b2b_first");
    frame1(0, 1'b0, "b2b_second");
    tick();

    // Mid-frame reset at index 4, divider 5.
    send_start = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      tick();
      send_start = 1'b0;
    end
    check("pre_rst_idx", {28'd0, baud_counte}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst", pack1(send_ready, baud_busy, baud_counte, send_done), pack1(1'b1, 1'b0, 4'd0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_hold", pack1(send_ready, baud_busy, baud_counte, send_done), pack1(1'b1, 1'b0, 4'd0, 1'b0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_nodone", pack1(send_ready, baud_busy, baud_counte, send_done), pack1(1'b1, 1'b0, 4'd0, 1'b0));
    end
    frame1(0, 1'b0, "after_rst");
    tick();

    // STOP_BITS=2 with serialiser, data 8'hA5.
    exp_line    = 11'b11101001010;
    tx_data2    = 8'hA5;
    send_start2 = 1'b1;
    for (int c = 1; c <= 89; c++) begin
      tick();
      send_start2 = 1'b0;
      if (c <= 88) begin
        e_idx = 4'((c - 1) / 8);
        check("stop2", pack1(send_ready2, baud_busy2, baud_counte2, send_done2), pack1(1'b0, 1'b1, e_idx, 1'b0));
      end else begin
        check("stop2_done", pack1(send_ready2, baud_busy2, baud_counte2, send_done2), pack1(1'b1, 1'b0, 4'd0, 1'b1));
      end
      if ((c >= 5) && ((c - 5) % 8 == 0) && ((c - 5) / 8 <= 10)) begin
        check("line_bit", {31'd0, line}, {31'd0, exp_line[(c - 5) / 8]});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
